// File: rtl/float8_mul_seq_if.sv
// Operand/result handshake bundle for the sequential float8 multiplier.
// The slave side is the multiplier; the master side feeds operands and consumes results.
interface float8_mul_seq_if #(
  parameter int MW = 8,
  parameter int PW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] fa;
  logic [PW-1:0] pa;
  logic [MW-1:0] fb;
  logic [PW-1:0] pb;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] fr;
  logic [PW:0]   pr;
  logic          zero;
  logic          inexact;

  modport master (
    output in_valid, fa, pa, fb, pb, out_ready,
    input  in_ready, out_valid, fr, pr, zero, inexact
  );

  modport slave (
    input  in_valid, fa, pa, fb, pb, out_ready,
    output in_ready, out_valid, fr, pr, zero, inexact
  );
endinterface

// File: rtl/float8_mul_seq.sv
// Shift-add multiplier for normalized MW-bit mantissa / PW-bit exponent floats.
// Fixed latency: MW multiply cycles, one renormalize cycle, then a held result.
module float8_mul_seq #(
  parameter int MW = 8,
  parameter int PW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  float8_mul_seq_if.slave bus
);
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t          state_reg,   state_next;
  logic [MW-1:0]   fa_reg,      fa_next;
  logic [MW-1:0]   fb_reg,      fb_next;
  logic [PW-1:0]   pa_reg,      pa_next;
  logic [PW-1:0]   pb_reg,      pb_next;
  logic [2*MW-1:0] mcand_reg,   mcand_next;
  logic [2*MW-1:0] prod_reg,    prod_next;
  logic [CW-1:0]   cnt_reg,     cnt_next;
  logic [MW-1:0]   fr_reg,      fr_next;
  logic [PW:0]     pr_reg,      pr_next;
  logic            zero_reg,    zero_next;
  logic            inexact_reg, inexact_next;

  logic [PW:0]     exp_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      fa_reg      <= '0;
      fb_reg      <= '0;
      pa_reg      <= '0;
      pb_reg      <= '0;
      mcand_reg   <= '0;
      prod_reg    <= '0;
      cnt_reg     <= '0;
      fr_reg      <= '0;
      pr_reg      <= '0;
      zero_reg    <= 1'b0;
      inexact_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fa_reg      <= fa_next;
      fb_reg      <= fb_next;
      pa_reg      <= pa_next;
      pb_reg      <= pb_next;
      mcand_reg   <= mcand_next;
      prod_reg    <= prod_next;
      cnt_reg     <= cnt_next;
      fr_reg      <= fr_next;
      pr_reg      <= pr_next;
      zero_reg    <= zero_next;
      inexact_reg <= inexact_next;
    end
  end

  assign exp_sum = {1'b0, pa_reg} + {1'b0, pb_reg};

  always_comb begin
    state_next   = state_reg;
    fa_next      = fa_reg;
    fb_next      = fb_reg;
    pa_next      = pa_reg;
    pb_next      = pb_reg;
    mcand_next   = mcand_reg;
    prod_next    = prod_reg;
    cnt_next     = cnt_reg;
    fr_next      = fr_reg;
    pr_next      = pr_reg;
    zero_next    = zero_reg;
    inexact_next = inexact_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          fa_next    = bus.fa;
          fb_next    = bus.fb;
          pa_next    = bus.pa;
          pb_next    = bus.pb;
          mcand_next = {{MW{1'b0}}, bus.fa};
          prod_next  = '0;
          cnt_next   = '0;
          state_next = MUL;
        end
      end
      MUL: begin
        // mcand_reg always holds fa << cnt_reg, so no barrel shifter is needed
        if (fb_reg[cnt_reg])
          prod_next = prod_reg + mcand_reg;
        mcand_next = mcand_reg << 1;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CW'(MW - 1))
          state_next = NORM;
      end
      NORM: begin
        if (!fa_reg[MW-1] || !fb_reg[MW-1]) begin
          fr_next      = '0;
          pr_next      = '0;
          zero_next    = 1'b1;
          inexact_next = 1'b0;
        end else if (prod_reg[2*MW-1]) begin
          fr_next      = prod_reg[2*MW-1 -: MW];
          pr_next      = exp_sum + 1'b1;
          zero_next    = 1'b0;
          inexact_next = |prod_reg[MW-1:0];
        end else begin
          // two normalized mantissas always yield at least bit 2MW-2 set
          fr_next      = prod_reg[2*MW-2 -: MW];
          pr_next      = exp_sum;
          zero_next    = 1'b0;
          inexact_next = |prod_reg[MW-2:0];
        end
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.fr        = fr_reg;
  assign bus.pr        = pr_reg;
  assign bus.zero      = zero_reg;
  assign bus.inexact   = inexact_reg;
endmodule

// File: tb/tb_float8_mul_seq.sv
// Scoreboard bench for float8_mul_seq: expected results are queued at accept
// and compared when the multiplier presents its result.
module tb_float8_mul_seq;
  logic clk;
  logic rst_n;

  float8_mul_seq_if bus ();

  float8_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] fr;
    logic [3:0] pr;
    logic       zero;
    logic       inexact;
  } res_t;

  res_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer multiply, then pick the top MW bits of the product.
  function automatic res_t model(input logic [7:0] a, input logic [2:0] ea,
                                 input logic [7:0] b, input logic [2:0] eb);
    res_t r;
    logic [15:0] p;
    r = '0;
    if (!a[7] || !b[7]) begin
      r.zero = 1'b1;
    end else begin
      p = 16'(a) * 16'(b);
      if (p >= 16'h8000) begin
        r.fr      = 8'(p / 256);
        r.pr      = 4'(ea) + 4'(eb) + 4'd1;
        r.inexact = (p % 256) != 0;
      end else begin
        r.fr      = 8'(p / 128);
        r.pr      = 4'(ea) + 4'(eb);
        r.inexact = (p % 128) != 0;
      end
    end
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.fr      = bus.fr;
    r.pr      = bus.pr;
    r.zero    = bus.zero;
    r.inexact = bus.inexact;
    return r;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [2:0] ea,
                        input logic [7:0] b, input logic [2:0] eb, input int hold);
    int   lat;
    logic busy_ok;
    logic stable_ok;
    res_t snap;
    res_t exp_r;
    bus.out_ready = (hold == 0);
    for (int i = 0; i < 20 && !bus.in_ready; i++) begin
      @(posedge clk); #1;
    end
    check_val("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.fa = a; bus.pa = ea; bus.fb = b; bus.pb = eb;
    @(posedge clk);
    sb_q.push_back(model(a, ea, b, eb));
    #1;
    // scramble inputs: the operation in flight must not see them
    bus.in_valid = 1'b0;
    bus.fa = 8'($urandom); bus.fb = 8'($urandom);
    bus.pa = 3'($urandom); bus.pb = 3'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 30) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", 32'(lat), 32'd9);
    check_val("in_ready_busy", 32'(busy_ok), 32'd1);
    snap = observed();
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!bus.out_valid || bus.in_ready || observed() !== snap) stable_ok = 1'b0;
      end
      check_val("backpressure_stable", 32'(stable_ok), 32'd1);
    end
    if (sb_q.size() > 0) begin
      exp_r = sb_q.pop_front();
      check_val("fr", 32'(bus.fr), 32'(exp_r.fr));
      check_val("pr", 32'(bus.pr), 32'(exp_r.pr));
      check_val("zero", 32'(bus.zero), 32'(exp_r.zero));
      check_val("inexact", 32'(bus.inexact), 32'(exp_r.inexact));
    end else begin
      check_val("scoreboard_empty", 32'd1, 32'(sb_q.size()));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check_val("in_ready_back", 32'(bus.in_ready), 32'd1);
    $display("op %02h*2^%0d x %02h*2^%0d hold=%0d -> fr=%02h pr=%0d zero=%0b inexact=%0b lat=%0d",
             a, ea, b, eb, hold, snap.fr, snap.pr, snap.zero, snap.inexact, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_fr"},        32'(bus.fr),        32'd0);
    check_val({tag, "_pr"},        32'(bus.pr),        32'd0);
    check_val({tag, "_zero"},      32'(bus.zero),      32'd0);
    check_val({tag, "_inexact"},   32'(bus.inexact),   32'd0);
  endtask

  task automatic reset_mid_mul();
    logic quiet_ok;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.fa = 8'hE3; bus.pa = 3'd4; bus.fb = 8'h9D; bus.pb = 3'd6;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_mul");
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) quiet_ok = 1'b0;
    end
    check_val("rst_no_stale_out", 32'(quiet_ok), 32'd1);
    $display("reset asserted mid-MUL, operation discarded");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a, b;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fa = '0; bus.pa = '0; bus.fb = '0; bus.pb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h80, 3'd7, 8'h80, 3'd7, 0);
    run_op(8'hFF, 3'd7, 8'hFF, 3'd7, 0);
    run_op(8'hC0, 3'd1, 8'hA0, 3'd2, 0);
    run_op(8'h00, 3'd0, 8'hB0, 3'd5, 0);
    run_op(8'hD5, 3'd3, 8'h81, 3'd2, 5);
    reset_mid_mul();
    run_op(8'hC0, 3'd1, 8'hA0, 3'd2, 0);

    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom) | 8'h80;
      if (i % 5 != 0) a = a | 8'h80;
      else a = a & 8'h7F;
      run_op(a, 3'($urandom), b, 3'($urandom), i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
